// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS sequencer and its datapath.
// master: the sequencer (samples opcode/funct/mem_ready, drives every select/enable).
// slave : the datapath side (drives opcode/funct/mem_ready, consumes the controls).
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_source, state, illegal
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_source, state, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath (shared memory, IR/MDR/ALUOut).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; returns to FETCH and clears the fault
//   bus    multicycle_control_if.master: opcode/funct/mem_ready in, all datapath
//          selects/enables, debug state and sticky illegal out
// Parameters: MEM_TIMEOUT (stall limit), CNT_W (wait counter width).
// Build option: define MEM_WAIT_EN to make FETCH/MEM_READ/MEM_WRITE wait on
// mem_ready with a stall timeout into HALT; otherwise memory states take one cycle.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_HALT      = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_RFN = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_LUI = 3'd6;

    state_t r_state;
    state_t w_next;
    logic   w_mem_done;   // memory finished its access this cycle
    logic   w_stall;      // hold current memory state
    logic   w_timeout;    // stall limit hit, fault next edge

`ifdef MEM_WAIT_EN
    logic             w_mem_state;
    logic [CNT_W-1:0] r_wait_cnt;

    assign w_mem_done  = bus.mem_ready;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                         (r_state == S_MEM_WRITE);
    assign w_stall     = w_mem_state && !bus.mem_ready;
    assign w_timeout   = w_mem_state && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

    // Consecutive stall counter; any completion, exit or fault clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_stall && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    logic w_unused;

    assign w_mem_done = 1'b1;
    assign w_stall    = 1'b0;
    assign w_timeout  = 1'b0;
    assign w_unused   = bus.mem_ready ^ (MEM_TIMEOUT == 0) ^ (CNT_W == 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; opcode/funct only matter in the states that branch on them.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                               w_next = (bus.funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW, OP_SW:                           w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                         w_next = S_BRANCH;
                    OP_J:                                   w_next = S_JUMP;
                    OP_JAL:                                 w_next = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_I_EXEC;
                    default:                                w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: w_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: w_next = S_MEM_WB;
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
        if (w_stall) begin
            w_next = r_state;
        end
        if (w_timeout) begin
            w_next = S_HALT;
        end
    end

    // Output decode from the current state.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'd0;
        bus.mem_to_reg    = 2'd0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = 2'd0;
        bus.state         = r_state;
        bus.illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = w_mem_done;
                bus.pc_write  = w_mem_done;
                bus.alu_src_b = 2'd1;
            end
            S_DECODE:   bus.alu_src_b = 2'd3;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'd1;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_RFN;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'd1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'd1;
                bus.branch_ne     = (bus.opcode == OP_BNE);
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'd2;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                case (bus.opcode)
                    OP_SLTI: bus.alu_op = ALU_SLT;
                    OP_ANDI: bus.alu_op = ALU_AND;
                    OP_ORI:  bus.alu_op = ALU_OR;
                    OP_LUI:  bus.alu_op = ALU_LUI;
                    default: bus.alu_op = ALU_ADD;
                endcase
            end
            S_I_WB:     bus.reg_write = 1'b1;
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'd2;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'd2;
                bus.mem_to_reg = 2'd2;
            end
            S_JR: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'd3;
            end
            S_HALT:     bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
